// File: rtl/mult_div_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mult_div_unit : multicycle Booth multiply / restoring divide; MULT_DIV_UNSIGNED_EN adds op_unsigned
// Revision 1.0
// ----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
  state_t state, state_nxt;

  // acc carries one guard bit so Booth steps on -2^(W-1) never overflow
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    count;
  logic             is_u, is_div, neg_q, neg_r, zero_div;

  logic             in_u, b_zero, booth_add, booth_sub;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   ext, bsum, rem_sh, diff;

`ifdef MULT_DIV_UNSIGNED_EN
  assign in_u = op_unsigned;
`else
  assign in_u = 1'b0;
`endif

  assign b_zero = (b == '0);
  assign abs_a  = (!in_u && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (!in_u && b[WIDTH-1]) ? -b : b;

  always_comb begin
    ext       = is_u ? {1'b0, opnd} : {opnd[WIDTH-1], opnd};
    booth_add = is_u ? q[0] : (!q[0] && q_m1);
    booth_sub = !is_u && q[0] && !q_m1;
    bsum      = acc;
    if (booth_add)      bsum = acc + ext;
    else if (booth_sub) bsum = acc - ext;
    rem_sh    = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff      = rem_sh - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (op && b_zero) ? FIX : (op ? DIV : MULT);
      MULT, DIV: if (count == LAST) state_nxt = FIX;
      FIX:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      opnd     <= '0;
      count    <= '0;
      is_u     <= 1'b0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          count    <= '0;
          acc      <= '0;
          q_m1     <= 1'b0;
          is_u     <= in_u;
          is_div   <= op;
          zero_div <= op && b_zero;
          neg_q    <= !in_u && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r    <= !in_u && a[WIDTH-1];
          if (op) begin
            q    <= abs_a;
            opnd <= abs_b;
          end else begin
            q    <= b;
            opnd <= a;
          end
        end
        MULT: begin
          acc   <= {(is_u ? 1'b0 : bsum[WIDTH]), bsum[WIDTH:1]};
          q     <= {bsum[0], q[WIDTH-1:1]};
          q_m1  <= q[0];
          count <= count + 1'b1;
        end
        DIV: begin
          if (!diff[WIDTH]) begin
            acc <= diff;
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            acc <= rem_sh;
            q   <= {q[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_div) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= neg_q ? -q : q;
            hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end else begin
            hi <= acc[WIDTH-1:0];
            lo <= q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps
// Bench for mult_div_unit: latency-level reference model compared every cycle, plus literal checks.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op    = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
  logic         op_unsigned = 1'b0;
`endif
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
`ifdef MULT_DIV_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

  // Reference arithmetic straight from the operation definitions.
  function automatic void model_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic u, output logic [W-1:0] rh, output logic [W-1:0] rl,
                                   output logic z);
    longint      sx, sy;
    logic [63:0] r64;
    z  = o && (y == '0);
    rh = '0;
    rl = '0;
    sx = u ? longint'(x) : longint'($signed(x));
    sy = u ? longint'(y) : longint'($signed(y));
    if (!o) begin
      r64 = sx * sy;
      rh  = r64[63:32];
      rl  = r64[31:0];
    end else if (!z) begin
      r64 = sx / sy;
      rl  = r64[31:0];
      r64 = sx % sy;
      rh  = r64[31:0];
    end
  endfunction

  logic         m_busy = 0, m_done = 0, m_dz = 0, m_zero = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  int           m_left = 0;
  logic         m_u;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          if (m_zero) m_dz = 1;
          else begin
            m_hi = m_rhi;
            m_lo = m_rlo;
          end
        end
      end else if (start) begin
`ifdef MULT_DIV_UNSIGNED_EN
        m_u = op_unsigned;
`else
        m_u = 1'b0;
`endif
        model_op(op, a, b, m_u, m_rhi, m_rlo, m_zero);
        m_left = m_zero ? 1 : W + 1;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({busy, done, div_zero, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
      errors++;
      $display("FAIL cycle @%0t: got busy=%b done=%b dz=%b hi=%h lo=%h, expected busy=%b done=%b dz=%b hi=%h lo=%h",
               $time, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation from a negedge; returns edges from the start edge to the done edge.
  task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic u,
                       input int poke, output int lat, output logic dz);
    int k;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
`ifdef MULT_DIV_UNSIGNED_EN
    op_unsigned = u;
`else
    if (u) $display("note: unsigned request ignored in signed-only build");
`endif
    k   = 0;
    lat = -1;
    dz  = 1'b0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (poke > 0 && k == poke) begin start = 1'b1; a = ~x; b = x ^ y; op = ~o; end
      if (poke > 0 && k == poke + 1) start = 1'b0;
      if (done) begin
        lat = k - 1;
        dz  = div_zero;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL timeout: no done within 60 cycles, got none expected done");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0001;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int           lat;
    logic         dz;
    logic         seen;
    logic [W-1:0] ra, rb;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {31'b0, busy, done, div_zero, hi, lo}, 64'h0);
    #2 reset = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd7, -32'sd3, 1'b0, 0, lat, dz);
    check("mult7x-3_lat", 64'(lat), 64'd33);
    check("mult7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, lat, dz);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

    do_op(1'b1, -32'sd7, 32'd2, 1'b0, 0, lat, dz);
    check("div-7/2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div-7/2_dz", 64'(dz), 64'd0);

    do_op(1'b1, 32'd5, 32'd0, 1'b0, 0, lat, dz);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_flag", 64'(dz), 64'd1);
    check("div0_hold", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, lat, dz);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

    do_op(1'b0, 32'd3, 32'd5, 1'b0, 10, lat, dz);
    check("poke_ignored", {hi, lo}, 64'd15);
    check("poke_lat", 64'(lat), 64'd33);

    do_op(1'b1, 32'd100, 32'd7, 1'b0, 0, lat, dz);
    do_op(1'b1, -32'sd100, 32'd7, 1'b0, 0, lat, dz);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_div", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

`ifdef MULT_DIV_UNSIGNED_EN
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, lat, dz);
    check("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd16, 1'b1, 0, lat, dz);
    check("divu", {hi, lo}, 64'h0000_000F_0FFF_FFFF);
`endif

    // Abort a division with reset partway through.
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd1000000; b = 32'd3;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    #2 reset = 1'b0;
    #1 check("reset_abort", {31'b0, busy, done, div_zero, hi, lo}, 64'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);

    for (int n = 0; n < 60; n++) begin
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      do_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 0, lat, dz);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end
endmodule
